// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, branch-flush and shared-bus stall control for PC, IF/ID and ID/EX
module hazard_stall_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Rx_a_IFID,
  input  logic [2:0]  Ry_a_IFID,
  input  logic        readRx_a_IFID,
  input  logic        readRy_a_IFID,
  input  logic        readSpecReg_a_IFID,
  input  logic        memRead_a_IDEX,
  input  logic [2:0]  registerToWriteId_a_IDEX,
  input  logic        writeSpecReg_a_IDEX,
  input  logic        memAccess_a_EXMEM,
  input  logic        branchTaken_a_EX,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic        holdPipe,
  output logic [15:0] stallCycles,
  output logic [7:0]  flushCount
);
  typedef enum logic {RUN, MEM_STALL} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT > 1 ? MEM_WAIT - 2 : 0);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic hz, go, freeze, fin, br;
  assign hz = memRead_a_IDEX & (
      (readRx_a_IFID & !writeSpecReg_a_IDEX & (Rx_a_IFID == registerToWriteId_a_IDEX)) |
      (readRy_a_IFID & !writeSpecReg_a_IDEX & (Ry_a_IFID == registerToWriteId_a_IDEX)) |
      (readSpecReg_a_IFID & writeSpecReg_a_IDEX));
  assign go = memAccess_a_EXMEM & (MEM_WAIT > 1);
  assign br = branchTaken_a_EX;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stallCycles <= 16'd0;
      flushCount  <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      stallCycles <= stallCycles + 16'(!pcWrite);
      flushCount  <= flushCount + 8'(br & !holdPipe);
    end
  end
  always_comb begin
    state_n = (state == RUN) ? (go ? MEM_STALL : RUN) : (cnt != 4'd0 ? MEM_STALL : RUN);
    cnt_n   = (state == RUN) ? (go ? CNT_INIT : cnt) : (cnt != 4'd0 ? cnt - 4'd1 : cnt);
  end
  // The final bus cycle suppresses fetch unless a branch or load-use overrides it
  always_comb begin
    freeze     = (state == RUN) ? go : (cnt != 4'd0);
    fin        = (state == RUN) ? (memAccess_a_EXMEM & (MEM_WAIT == 1)) : (cnt == 4'd0);
    pcWrite    = !rst & !freeze & (br | (!fin & !hz));
    ifidWrite  = rst | (!freeze & (br | !hz));
    ifidFlush  = rst | (!freeze & (br | (fin & !hz)));
    idexBubble = rst | (!freeze & (br | hz));
    holdPipe   = !rst & freeze;
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of hazard_stall_unit with MEM_WAIT=1 and MEM_WAIT=3 instances
module tb_hazard_stall_unit;
  logic clk = 0, rst = 1;
  logic [2:0] rx = 0, ry = 0, rd = 0;
  logic rdx = 0, rdy = 0, rds = 0, mrd = 0, wsp = 0, macc = 0, br = 0;
  logic pc1, ifw1, fl1, bub1, hold1, pc3, ifw3, fl3, bub3, hold3;
  logic [15:0] stall1, stall3;
  logic [7:0] flush1, flush3;
  logic [4:0] ctl1, ctl3;
  int tests = 0, fails = 0;
  assign ctl1 = {pc1, ifw1, fl1, bub1, hold1};
  assign ctl3 = {pc3, ifw3, fl3, bub3, hold3};
  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .Rx_a_IFID(rx), .Ry_a_IFID(ry), .readRx_a_IFID(rdx),
    .readRy_a_IFID(rdy), .readSpecReg_a_IFID(rds), .memRead_a_IDEX(mrd),
    .registerToWriteId_a_IDEX(rd), .writeSpecReg_a_IDEX(wsp), .memAccess_a_EXMEM(macc),
    .branchTaken_a_EX(br), .pcWrite(pc1), .ifidWrite(ifw1), .ifidFlush(fl1),
    .idexBubble(bub1), .holdPipe(hold1), .stallCycles(stall1), .flushCount(flush1));

  hazard_stall_unit #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .Rx_a_IFID(rx), .Ry_a_IFID(ry), .readRx_a_IFID(rdx),
    .readRy_a_IFID(rdy), .readSpecReg_a_IFID(rds), .memRead_a_IDEX(mrd),
    .registerToWriteId_a_IDEX(rd), .writeSpecReg_a_IDEX(wsp), .memAccess_a_EXMEM(macc),
    .branchTaken_a_EX(br), .pcWrite(pc3), .ifidWrite(ifw3), .ifidFlush(fl3),
    .idexBubble(bub3), .holdPipe(hold3), .stallCycles(stall3), .flushCount(flush3));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // ctl = {pcWrite, ifidWrite, ifidFlush, idexBubble, holdPipe}
  initial begin
    @(negedge clk);
    chk("rst_ctl1", 16'(ctl1), 16'b01110);
    chk("rst_ctl3", 16'(ctl3), 16'b01110);
    nxt();
    rst = 0;
    chk("rst_stall1", stall1, 16'd0);
    chk("rst_flush1", 16'(flush1), 16'd0);
    chk("rst_stall3", stall3, 16'd0);
    @(negedge clk);
    chk("idle_ctl1", 16'(ctl1), 16'b11000);
    nxt();
    mrd = 1; rd = 3; rx = 3; rdx = 1;
    @(negedge clk);
    chk("lu_ctl1", 16'(ctl1), 16'b00010);
    nxt();
    mrd = 0;
    @(negedge clk);
    chk("lu_after_ctl1", 16'(ctl1), 16'b11000);
    chk("lu_stall1", stall1, 16'd1);
    nxt();
    mrd = 1; wsp = 1; rds = 1;
    @(negedge clk);
    chk("spec_ctl1", 16'(ctl1), 16'b00010);
    nxt();
    rds = 0;
    @(negedge clk);
    chk("spec_norx_ctl1", 16'(ctl1), 16'b11000);
    nxt();
    wsp = 0; br = 1;
    @(negedge clk);
    chk("br_hz_ctl1", 16'(ctl1), 16'b11110);
    nxt();
    mrd = 0; br = 0; rdx = 0;
    chk("br_flush1", 16'(flush1), 16'd1);
    chk("br_stall1", stall1, 16'd2);
    chk("pre_mem_stall3", stall3, 16'd2);
    macc = 1;
    @(negedge clk);
    chk("mem_c1_ctl3", 16'(ctl3), 16'b00001);
    chk("mem_w1_ctl1", 16'(ctl1), 16'b01100);
    nxt();
    @(negedge clk);
    chk("mem_c2_ctl3", 16'(ctl3), 16'b00001);
    nxt();
    @(negedge clk);
    chk("mem_c3_ctl3", 16'(ctl3), 16'b01100);
    nxt();
    macc = 0;
    @(negedge clk);
    chk("mem_done_ctl3", 16'(ctl3), 16'b11000);
    chk("mem_stall3", stall3, 16'd5);
    nxt();
    macc = 1; br = 1;
    @(negedge clk);
    chk("mbr_c1_ctl3", 16'(ctl3), 16'b00001);
    nxt();
    @(negedge clk);
    chk("mbr_c2_ctl3", 16'(ctl3), 16'b00001);
    chk("mbr_frozen_flush3", 16'(flush3), 16'd1);
    nxt();
    @(negedge clk);
    chk("mbr_c3_ctl3", 16'(ctl3), 16'b11110);
    nxt();
    macc = 0; br = 0;
    chk("mbr_flush3", 16'(flush3), 16'd2);
    chk("mbr_stall3", stall3, 16'd7);
    @(negedge clk);
    chk("mbr_done_ctl3", 16'(ctl3), 16'b11000);
    nxt();
    macc = 1;
    @(negedge clk);
    chk("rmid_c1_ctl3", 16'(ctl3), 16'b00001);
    nxt();
    rst = 1;
    @(negedge clk);
    chk("rmid_rst_ctl3", 16'(ctl3), 16'b01110);
    nxt();
    rst = 0; macc = 0;
    @(negedge clk);
    chk("rmid_after_ctl3", 16'(ctl3), 16'b11000);
    chk("rmid_stall3", stall3, 16'd0);
    chk("rmid_flush3", 16'(flush3), 16'd0);
    nxt();
    chk("rmid_stall3_hold", stall3, 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline-control block in the ID stage, complementing the forwarding path. It handles the hazards that forwarding cannot resolve, and drives the hold, flush and bubble controls of the PC, IF/ID and ID/EX registers:
- load-use hazards (a load in EX feeding the instruction in ID);
- taken-branch redirects;
- structural stalls when the MEM stage occupies the shared instruction-memory bus.

It also keeps stall and flush counters for debug.

## Interface
Parameters:
- MEM_WAIT, 1: total cycles a shared-bus MEM access occupies EX/MEM; legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- Rx_a_IFID  in  3  first source register of the instruction in ID.
- Ry_a_IFID  in  3  second source register of the instruction in ID.
- readRx_a_IFID  in  1  the ID instruction really reads Rx.
- readRy_a_IFID  in  1  the ID instruction really reads Ry.
- readSpecReg_a_IFID  in  1  the ID instruction reads a special register (T/SP/IH).
- memRead_a_IDEX  in  1  the EX instruction is a load.
- registerToWriteId_a_IDEX  in  3  destination of the EX instruction.
- writeSpecReg_a_IDEX  in  1  the EX instruction writes a special register (not a general register).
- memAccess_a_EXMEM  in  1  the MEM instruction uses the shared instruction-memory bus.
- branchTaken_a_EX  in  1  the branch/jump in EX resolved taken.
- pcWrite  out  1  PC may load its next value.
- ifidWrite  out  1  IF/ID may load.
- ifidFlush  out  1  IF/ID loads a NOP (only meaningful when ifidWrite=1).
- idexBubble  out  1  ID/EX loads a NOP.
- holdPipe  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stallCycles  out  16  count of cycles with pcWrite=0 outside reset; wraps.
- flushCount  out  8  count of taken-branch flushes; wraps.

## Operation
Load-use hazard, defined as `hz = memRead_a_IDEX & (X | Y | S)`, where:
- `X = readRx_a_IFID & !writeSpecReg_a_IDEX & (Rx_a_IFID == registerToWriteId_a_IDEX)`;
- `Y` is the same test for Ry;
- `S = readSpecReg_a_IFID & writeSpecReg_a_IDEX`.

The FSM has two states, RUN and MEM_STALL, plus a 4-bit counter `cnt`. Outputs are combinational from the state and the inputs.

Default outputs:
- pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, holdPipe=0.

"Final-cycle rules" apply in RUN when memAccess_a_EXMEM=1 and MEM_WAIT=1, and in MEM_STALL when cnt==0. They are evaluated in priority order:
1. branchTaken_a_EX: pcWrite=1, ifidFlush=1, idexBubble=1.
2. hz: pcWrite=0, ifidWrite=0, idexBubble=1.
3. Otherwise: pcWrite=0, ifidFlush=1 (fetch suppressed; the ID instruction advances).

RUN, in priority order:
- memAccess_a_EXMEM=1 and MEM_WAIT>1: holdPipe=1, pcWrite=0, ifidWrite=0; cnt<=MEM_WAIT-2; next state MEM_STALL.
- memAccess_a_EXMEM=1 and MEM_WAIT=1: apply the final-cycle rules; stay in RUN.
- branchTaken_a_EX: pcWrite=1, ifidFlush=1, idexBubble=1; a taken branch overrides hz.
- hz: pcWrite=0, ifidWrite=0, idexBubble=1.

MEM_STALL:
- memAccess_a_EXMEM is ignored, because EX/MEM is frozen and still holds the same access.
- cnt!=0: holdPipe=1, pcWrite=0, ifidWrite=0; cnt<=cnt-1.
- cnt==0: holdPipe=0; apply the final-cycle rules; next state RUN.

Counters:
- stallCycles increments on every non-reset cycle with pcWrite=0.
- flushCount increments on every non-reset cycle with branchTaken_a_EX=1 that is not frozen by holdPipe=1.

## Timing
- Reset:
  - State after reset: state=RUN, cnt=0, stallCycles=0, flushCount=0.
  - Outputs while rst=1: pcWrite=0, ifidWrite=1, ifidFlush=1, idexBubble=1, holdPipe=0.
- Reset mid-MEM_STALL: at the next edge the FSM is in RUN and the counters are zero; no residual freeze.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load has left EX, so hz deasserts and forwarding supplies the operand.
- A shared-bus access costs exactly MEM_WAIT cycles with pcWrite=0:
  - MEM_WAIT-1 cycles with holdPipe=1;
  - then one advancing cycle with IF/ID flushed or held.
- A branch resolved during a freeze stays asserted because ID/EX is held. It is acted on, and counted, only in the final cycle.
- The back-to-back memAccess on the cycle after returning to RUN belongs to a new instruction and restarts the sequence.

## Test plan
1. Load r3 in EX, ID reads Rx=3 with readRx=1, MEM_WAIT=1 → one cycle of pcWrite=0, ifidWrite=0, idexBubble=1; next cycle all defaults; stallCycles=1.
2. Load to SP in EX (writeSpecReg=1, registerToWriteId=3), ID has readSpecReg=1 and Rx=3 → hz from S only. Repeat with readSpecReg=0 → no stall; the Rx match is ignored.
3. branchTaken=1 together with hz → pcWrite=1, ifidFlush=1, idexBubble=1, no stall; flushCount 0→1.
4. MEM_WAIT=3, memAccess held 3 cycles → cycles 1–2: holdPipe=1, pcWrite=0, ifidWrite=0; cycle 3: holdPipe=0, pcWrite=0, ifidFlush=1; state back in RUN; stallCycles=3.
5. MEM_WAIT=3 with branchTaken=1 throughout → freeze for 2 cycles with flushCount unchanged; cycle 3: pcWrite=1, ifidFlush=1, idexBubble=1; flushCount=1.
6. Assert rst during cycle 2 of test 4 → reset outputs that cycle; after release, defaults with memAccess=0; both counters 0.
